// File: rtl/flow_pkg.sv
// Shared sizing, types and FSM encoding for the flow interleaver.
package flow_pkg;

  localparam int unsigned FLUX   = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned TAG_W  = $clog2(FLUX);
  localparam int unsigned LEN_W  = 7;

  typedef logic [TAG_W-1:0] flow_tag_t;
  typedef logic [LEN_W-1:0] row_len_t;

  typedef enum logic [0:0] {
    ARB,
    BURST
  } il_state_t;

endpackage

// File: rtl/flow_rr_pick.sv
// Combinational round-robin picker: first eligible index after `last`, wrapping.
module flow_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] rot;
  int unsigned  base;

  // Rotate so bit 0 is flow last+1, then take the lowest set bit.
  always_comb begin
    base = 32'(last) + 32'd1;
    rot  = N'({eligible, eligible} >> base);
    hit  = 1'b0;
    idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!hit && rot[k]) begin
        hit = 1'b1;
        idx = IDX_W'((base + k) % N);
      end
    end
  end

endmodule

// File: rtl/flow_interleaver.sv
// Merges FLUX per-flow FWFT FIFOs into one tagged pixel stream, one row-sized burst per grant.
module flow_interleaver
  import flow_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLUX*DATA_W-1:0]  src_dout,
  input  logic [FLUX-1:0]         src_empty,
  output logic [FLUX-1:0]         src_read,
  input  logic [TAG_W+LEN_W-1:0]  cfg_din,
  input  logic                    cfg_write,
  output logic [TAG_W+DATA_W-1:0] out_din,
  output logic                    out_write,
  input  logic [FLUX-1:0]         out_full
);

  il_state_t state_q, state_d;
  flow_tag_t last_q, last_d;
  flow_tag_t cur_q, cur_d;
  row_len_t  burst_len_q, burst_len_d;
  row_len_t  cnt_q, cnt_d;
  row_len_t  row_len_q [FLUX];

  logic [TAG_W+DATA_W-1:0] out_din_q, out_din_d;
  logic                    out_write_q, out_write_d;

  logic [DATA_W-1:0] src_pix [FLUX];
  logic [FLUX-1:0]   eligible;
  logic              pick_hit;
  flow_tag_t         pick_idx;
  flow_tag_t         cfg_tag;
  row_len_t          cfg_len;
  logic              pop;

  assign cfg_tag = cfg_din[TAG_W+LEN_W-1 -: TAG_W];
  assign cfg_len = cfg_din[LEN_W-1:0];

  for (genvar g = 0; g < FLUX; g++) begin : g_pix
    assign src_pix[g] = src_dout[g*DATA_W +: DATA_W];
  end

  // A flow may be granted only if enabled, holding data and with downstream room.
  always_comb begin
    for (int unsigned i = 0; i < FLUX; i++) begin
      eligible[i] = (row_len_q[i] != '0) && !src_empty[i] && !out_full[i];
    end
  end

  flow_rr_pick #(
    .N     (FLUX),
    .IDX_W (TAG_W)
  ) u_pick (
    .eligible (eligible),
    .last     (last_q),
    .hit      (pick_hit),
    .idx      (pick_idx)
  );

  // Next-state, pop and output-register logic for the ARB/BURST FSM.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cur_d       = cur_q;
    burst_len_d = burst_len_q;
    cnt_d       = cnt_q;
    out_din_d   = out_din_q;
    out_write_d = 1'b0;
    src_read    = '0;
    pop         = 1'b0;

    unique case (state_q)
      ARB: begin
        // Grant cycle never pops; this is the one idle cycle between bursts.
        if (pick_hit) begin
          cur_d       = pick_idx;
          burst_len_d = row_len_q[pick_idx];
          cnt_d       = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        // Empty or full only pauses the row; the burst is never abandoned.
        pop             = !src_empty[cur_q] && !out_full[cur_q];
        src_read[cur_q] = pop;
        if (pop) begin
          out_din_d   = {cur_q, src_pix[cur_q]};
          out_write_d = 1'b1;
          cnt_d       = cnt_q + row_len_t'(1);
          if (cnt_q == burst_len_q - row_len_t'(1)) begin
            last_d  = cur_q;
            state_d = ARB;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // FSM, burst bookkeeping and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB;
      last_q      <= flow_tag_t'(FLUX - 1);
      cur_q       <= '0;
      burst_len_q <= '0;
      cnt_q       <= '0;
      out_din_q   <= '0;
      out_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cur_q       <= cur_d;
      burst_len_q <= burst_len_d;
      cnt_q       <= cnt_d;
      out_din_q   <= out_din_d;
      out_write_q <= out_write_d;
    end
  end

  // Per-flow row length; a write here is seen by the next ARB evaluation, not this one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FLUX; i++) begin
        row_len_q[i] <= '0;
      end
    end else if (cfg_write) begin
      row_len_q[cfg_tag] <= cfg_len;
    end
  end

  assign out_din   = out_din_q;
  assign out_write = out_write_q;

  // Structural invariants: at most one pop, and the row counter stays inside the burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert ($onehot0(src_read));
      if (state_q == BURST) begin
        assert (cnt_q < burst_len_q);
      end
    end
  end

endmodule

// File: tb/tb_flow_interleaver.sv
// Scoreboarded bench for flow_interleaver: FIFO models feed the DUT, outputs are logged per cycle.
module tb_flow_interleaver;
  import flow_pkg::*;

  localparam int MEM_D = 1024;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [FLUX*DATA_W-1:0]  src_dout;
  logic [FLUX-1:0]         src_empty;
  logic [FLUX-1:0]         src_read;
  logic [TAG_W+LEN_W-1:0]  cfg_din;
  logic                    cfg_write;
  logic [TAG_W+DATA_W-1:0] out_din;
  logic                    out_write;
  logic [FLUX-1:0]         out_full;
  logic [FLUX-1:0]         force_empty;
  logic                    flush;

  // FIFO storage written by the bench; rd_ptr follows DUT pops, exp_rd is the scoreboard side.
  logic [DATA_W-1:0] mem    [FLUX][MEM_D];
  logic [9:0]        wr_cnt [FLUX];
  logic [9:0]        exp_rd [FLUX];
  logic [9:0]        rd_ptr [FLUX] = '{default: '0};
  int                pop_cnt [FLUX] = '{default: 0};
  int                multi_pop = 0;

  int tests_run;
  int tests_failed;
  int cyc;

  flow_tag_t         w_tag [$];
  logic [DATA_W-1:0] w_pix [$];
  int                w_cyc [$];
  flow_tag_t         r_tag [$];
  int                r_len [$];
  int                r_gap [$];

  flow_interleaver dut (
    .clk       (clk),
    .rst       (rst),
    .src_dout  (src_dout),
    .src_empty (src_empty),
    .src_read  (src_read),
    .cfg_din   (cfg_din),
    .cfg_write (cfg_write),
    .out_din   (out_din),
    .out_write (out_write),
    .out_full  (out_full)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      src_empty[i]                 = force_empty[i] || (rd_ptr[i] == wr_cnt[i]);
      src_dout[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i]];
    end
  end

  always @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < FLUX; i++) rd_ptr[i] <= wr_cnt[i];
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (src_read[i]) begin
          rd_ptr[i]  <= rd_ptr[i] + 10'd1;
          pop_cnt[i] <= pop_cnt[i] + 1;
        end
      end
    end
    if ($countones(src_read) > 1) multi_pop <= multi_pop + 1;
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      if (out_write) begin
        w_tag.push_back(out_din[TAG_W+DATA_W-1:DATA_W]);
        w_pix.push_back(out_din[DATA_W-1:0]);
        w_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic push(input flow_tag_t f, input int n);
    for (int k = 0; k < n; k++) begin
      mem[f][wr_cnt[f]] = DATA_W'($urandom);
      wr_cnt[f]         = wr_cnt[f] + 10'd1;
    end
  endtask

  task automatic cfg(input flow_tag_t f, input int len);
    cfg_din   = {f, row_len_t'(len)};
    cfg_write = 1'b1;
    step(1);
    cfg_write = 1'b0;
  endtask

  task automatic flush_fifos();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    for (int f = 0; f < FLUX; f++) exp_rd[f] = wr_cnt[f];
  endtask

  task automatic clear_log();
    w_tag.delete();
    w_pix.delete();
    w_cyc.delete();
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    for (int k = 0; k < budget && w_tag.size() < n; k++) step(1);
    ok = (w_tag.size() >= n);
  endtask

  // Group logged writes into runs: a run breaks on a tag change or any idle cycle.
  task automatic split_runs();
    r_tag.delete();
    r_len.delete();
    r_gap.delete();
    for (int j = 0; j < w_tag.size(); j++) begin
      if (j == 0 || w_tag[j] != w_tag[j-1] || w_cyc[j] - w_cyc[j-1] > 1) begin
        r_tag.push_back(w_tag[j]);
        r_len.push_back(1);
        r_gap.push_back((j == 0) ? 0 : w_cyc[j] - w_cyc[j-1] - 1);
      end else begin
        r_len[r_len.size()-1] = r_len[r_len.size()-1] + 1;
      end
    end
  endtask

  task automatic test_reset();
    step(2);
    tests_run++;
    if (out_write !== 1'b0 || src_read !== '0 || out_din !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got write=%b read=%b din=%h, want 0 0 0",
               out_write, src_read, out_din);
    end
    rst = 1'b1;
    clear_log();
    push(flow_tag_t'(0), 5);
    step(10);
    tests_run++;
    if (w_tag.size() != 0 || pop_cnt[0] != 0) begin
      tests_failed++;
      $display("FAIL reset_rowlen_zero: got %0d writes %0d pops, want 0 0",
               w_tag.size(), pop_cnt[0]);
    end
    flush_fifos();
  endtask

  task automatic test_basic();
    bit ok;
    flow_tag_t t;
    clear_log();
    for (int f = 0; f < FLUX; f++) push(flow_tag_t'(f), 529);
    for (int f = 0; f < FLUX; f++) cfg(flow_tag_t'(f), 23);
    wait_writes(2116, 3000, ok);
    step(5);
    tests_run++;
    if (!ok || w_tag.size() != 2116) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d writes, want 2116", w_tag.size());
    end
    split_runs();
    tests_run++;
    if (r_tag.size() != 92) begin
      tests_failed++;
      $display("FAIL basic_runs: got %0d runs, want 92", r_tag.size());
    end
    for (int r = 0; r < r_tag.size(); r++) begin
      tests_run++;
      if (r_tag[r] !== flow_tag_t'(r % FLUX) || r_len[r] != 23 || (r > 0 && r_gap[r] != 1)) begin
        tests_failed++;
        $display("FAIL basic_run %0d: got tag %0d len %0d gap %0d, want tag %0d len 23 gap 1",
                 r, r_tag[r], r_len[r], r_gap[r], r % FLUX);
      end
    end
    for (int j = 0; j < w_tag.size(); j++) begin
      t = w_tag[j];
      tests_run++;
      if (exp_rd[t] == wr_cnt[t] || w_pix[j] !== mem[t][exp_rd[t]]) begin
        tests_failed++;
        $display("FAIL basic_payload write %0d tag %0d: got %02h, want %02h",
                 j, t, w_pix[j], mem[t][exp_rd[t]]);
      end
      if (exp_rd[t] != wr_cnt[t]) exp_rd[t] = exp_rd[t] + 10'd1;
    end
  endtask

  task automatic test_skip_empty();
    bit ok;
    int p1;
    flow_tag_t t;
    int exp_order [6] = '{0, 2, 3, 0, 2, 3};
    clear_log();
    p1 = pop_cnt[1];
    push(flow_tag_t'(0), 46);
    push(flow_tag_t'(2), 46);
    push(flow_tag_t'(3), 46);
    wait_writes(138, 400, ok);
    step(5);
    split_runs();
    tests_run++;
    if (!ok || r_tag.size() != 6) begin
      tests_failed++;
      $display("FAIL skip_runs: got %0d runs, want 6", r_tag.size());
    end
    for (int r = 0; r < 6 && r < r_tag.size(); r++) begin
      tests_run++;
      if (r_tag[r] !== flow_tag_t'(exp_order[r]) || r_len[r] != 23) begin
        tests_failed++;
        $display("FAIL skip_run %0d: got tag %0d len %0d, want tag %0d len 23",
                 r, r_tag[r], r_len[r], exp_order[r]);
      end
    end
    tests_run++;
    if (pop_cnt[1] != p1) begin
      tests_failed++;
      $display("FAIL skip_read1: got %0d pops of flow 1, want 0", pop_cnt[1] - p1);
    end
    for (int j = 0; j < w_tag.size(); j++) begin
      t = w_tag[j];
      tests_run++;
      if (exp_rd[t] == wr_cnt[t] || w_pix[j] !== mem[t][exp_rd[t]]) begin
        tests_failed++;
        $display("FAIL skip_payload write %0d tag %0d: got %02h, want %02h",
                 j, t, w_pix[j], mem[t][exp_rd[t]]);
      end
      if (exp_rd[t] != wr_cnt[t]) exp_rd[t] = exp_rd[t] + 10'd1;
    end
  endtask

  task automatic test_stalls();
    bit ok1, ok2, ok3;
    int want_gap;
    clear_log();
    push(flow_tag_t'(0), 23);
    wait_writes(10, 100, ok1);
    force_empty[0] = 1'b1;
    step(3);
    force_empty[0] = 1'b0;
    wait_writes(15, 100, ok2);
    out_full[0] = 1'b1;
    step(2);
    out_full[0] = 1'b0;
    wait_writes(23, 100, ok3);
    step(5);
    tests_run++;
    if (!(ok1 && ok2 && ok3) || w_tag.size() != 23) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d writes, want 23", w_tag.size());
    end
    for (int j = 0; j < w_tag.size(); j++) begin
      want_gap = (j == 10) ? 4 : (j == 15) ? 3 : 1;
      tests_run++;
      if (w_tag[j] !== flow_tag_t'(0) || (j > 0 && w_cyc[j] - w_cyc[j-1] != want_gap)
          || exp_rd[0] == wr_cnt[0] || w_pix[j] !== mem[0][exp_rd[0]]) begin
        tests_failed++;
        $display("FAIL stall_write %0d: got tag %0d step %0d pix %02h, want tag 0 step %0d pix %02h",
                 j, w_tag[j], (j > 0) ? w_cyc[j] - w_cyc[j-1] : 0, w_pix[j], want_gap,
                 mem[0][exp_rd[0]]);
      end
      if (exp_rd[0] != wr_cnt[0]) exp_rd[0] = exp_rd[0] + 10'd1;
    end
  endtask

  task automatic test_full_arb();
    bit ok, seen3;
    flow_tag_t t;
    int exp_order [3] = '{1, 3, 2};
    clear_log();
    out_full[2] = 1'b1;
    push(flow_tag_t'(1), 23);
    push(flow_tag_t'(2), 23);
    push(flow_tag_t'(3), 23);
    seen3 = 1'b0;
    for (int k = 0; k < 200 && !seen3; k++) begin
      step(1);
      if (w_tag.size() > 0 && w_tag[w_tag.size()-1] == flow_tag_t'(3)) seen3 = 1'b1;
    end
    tests_run++;
    if (!seen3) begin
      tests_failed++;
      $display("FAIL full_grant3: got no flow-3 write in 200 cycles, want one");
    end
    out_full[2] = 1'b0;
    wait_writes(69, 300, ok);
    step(5);
    split_runs();
    tests_run++;
    if (!ok || r_tag.size() != 3) begin
      tests_failed++;
      $display("FAIL full_runs: got %0d runs, want 3", r_tag.size());
    end
    for (int r = 0; r < 3 && r < r_tag.size(); r++) begin
      tests_run++;
      if (r_tag[r] !== flow_tag_t'(exp_order[r]) || r_len[r] != 23) begin
        tests_failed++;
        $display("FAIL full_run %0d: got tag %0d len %0d, want tag %0d len 23",
                 r, r_tag[r], r_len[r], exp_order[r]);
      end
    end
    for (int j = 0; j < w_tag.size(); j++) begin
      t = w_tag[j];
      tests_run++;
      if (exp_rd[t] == wr_cnt[t] || w_pix[j] !== mem[t][exp_rd[t]]) begin
        tests_failed++;
        $display("FAIL full_payload write %0d tag %0d: got %02h, want %02h",
                 j, t, w_pix[j], mem[t][exp_rd[t]]);
      end
      if (exp_rd[t] != wr_cnt[t]) exp_rd[t] = exp_rd[t] + 10'd1;
    end
  endtask

  task automatic test_config();
    bit ok1, ok2;
    int p3;
    flow_tag_t t;
    int exp_order [4] = '{0, 1, 2, 0};
    int exp_len   [4] = '{23, 23, 23, 8};
    clear_log();
    cfg(flow_tag_t'(3), 0);
    p3 = pop_cnt[3];
    push(flow_tag_t'(0), 31);
    push(flow_tag_t'(1), 23);
    push(flow_tag_t'(2), 23);
    push(flow_tag_t'(3), 23);
    wait_writes(5, 100, ok1);
    cfg(flow_tag_t'(0), 8);
    wait_writes(77, 400, ok2);
    step(60);
    tests_run++;
    if (!(ok1 && ok2) || w_tag.size() != 77) begin
      tests_failed++;
      $display("FAIL cfg_count: got %0d writes, want 77", w_tag.size());
    end
    split_runs();
    tests_run++;
    if (r_tag.size() != 4) begin
      tests_failed++;
      $display("FAIL cfg_runs: got %0d runs, want 4", r_tag.size());
    end
    for (int r = 0; r < 4 && r < r_tag.size(); r++) begin
      tests_run++;
      if (r_tag[r] !== flow_tag_t'(exp_order[r]) || r_len[r] != exp_len[r]) begin
        tests_failed++;
        $display("FAIL cfg_run %0d: got tag %0d len %0d, want tag %0d len %0d",
                 r, r_tag[r], r_len[r], exp_order[r], exp_len[r]);
      end
    end
    tests_run++;
    if (pop_cnt[3] != p3) begin
      tests_failed++;
      $display("FAIL cfg_disabled3: got %0d pops of flow 3, want 0", pop_cnt[3] - p3);
    end
    for (int j = 0; j < w_tag.size(); j++) begin
      t = w_tag[j];
      tests_run++;
      if (exp_rd[t] == wr_cnt[t] || w_pix[j] !== mem[t][exp_rd[t]]) begin
        tests_failed++;
        $display("FAIL cfg_payload write %0d tag %0d: got %02h, want %02h",
                 j, t, w_pix[j], mem[t][exp_rd[t]]);
      end
      if (exp_rd[t] != wr_cnt[t]) exp_rd[t] = exp_rd[t] + 10'd1;
    end
    flush_fifos();
  endtask

  task automatic test_async_reset();
    bit ok1, ok2;
    int p2;
    flow_tag_t t;
    clear_log();
    push(flow_tag_t'(2), 23);
    wait_writes(12, 100, ok1);
    tests_run++;
    if (!ok1 || src_read !== 4'b0100) begin
      tests_failed++;
      $display("FAIL rst_midburst: got %0d writes read=%b, want 12 0100", w_tag.size(), src_read);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_write !== 1'b0 || src_read !== '0 || out_din !== '0) begin
      tests_failed++;
      $display("FAIL rst_async: got write=%b read=%b din=%h, want 0 0 0",
               out_write, src_read, out_din);
    end
    p2 = pop_cnt[2];
    step(3);
    tests_run++;
    if (pop_cnt[2] != p2) begin
      tests_failed++;
      $display("FAIL rst_nopop: got %0d pops during reset, want 0", pop_cnt[2] - p2);
    end
    flush_fifos();
    rst = 1'b1;
    out_full = '1;
    for (int f = 0; f < FLUX; f++) push(flow_tag_t'(f), 23);
    for (int f = FLUX - 1; f >= 0; f--) cfg(flow_tag_t'(f), 23);
    clear_log();
    out_full = '0;
    wait_writes(92, 300, ok2);
    split_runs();
    tests_run++;
    if (!ok2 || r_tag.size() != 4) begin
      tests_failed++;
      $display("FAIL rst_runs: got %0d runs, want 4", r_tag.size());
    end
    for (int r = 0; r < 4 && r < r_tag.size(); r++) begin
      tests_run++;
      if (r_tag[r] !== flow_tag_t'(r) || r_len[r] != 23) begin
        tests_failed++;
        $display("FAIL rst_run %0d: got tag %0d len %0d, want tag %0d len 23",
                 r, r_tag[r], r_len[r], r);
      end
    end
    for (int j = 0; j < w_tag.size(); j++) begin
      t = w_tag[j];
      tests_run++;
      if (exp_rd[t] == wr_cnt[t] || w_pix[j] !== mem[t][exp_rd[t]]) begin
        tests_failed++;
        $display("FAIL rst_payload write %0d tag %0d: got %02h, want %02h",
                 j, t, w_pix[j], mem[t][exp_rd[t]]);
      end
      if (exp_rd[t] != wr_cnt[t]) exp_rd[t] = exp_rd[t] + 10'd1;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    rst          = 1'b0;
    cfg_din      = '0;
    cfg_write    = 1'b0;
    out_full     = '0;
    force_empty  = '0;
    flush        = 1'b0;
    for (int f = 0; f < FLUX; f++) begin
      wr_cnt[f] = '0;
      exp_rd[f] = '0;
    end

    test_reset();
    test_basic();
    test_skip_empty();
    test_stalls();
    test_full_arb();
    test_config();
    test_async_reset();

    tests_run++;
    if (multi_pop != 0) begin
      tests_failed++;
      $display("FAIL onehot_read: got %0d multi-bit pop cycles, want 0", multi_pop);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
